count_event_monitor: RTL and testbench



---
 rtl/count_event_monitor.sv | 237 +++++++++++++++++++++++
 tb/tb_count_event_monitor.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_event_monitor.sv
// count_event_monitor
//   Observes a free-running up/down/load counter and classifies every step as
//   hold, up, down, wrap or jump. The observed value is extended with EXT_W
//   upper bits that follow wraps. A threshold on the extended value raises a
//   single pulse per arrival. Event records are queued in a small FIFO that a
//   consumer drains through a valid/ready handshake.
//
// Ports
//   clk           rising-edge clock
//   reset_n       asynchronous active-low reset
//   count         observed counter value, sampled every edge
//   clear         synchronous clear of tracking state, FIFO and overflow flag
//   threshold     extended-count match value
//   ext_count     {upper, last sample}
//   wrap_up       one-cycle pulse: max -> 0 step
//   wrap_down     one-cycle pulse: 0 -> max step
//   jump          one-cycle pulse: non-unit, non-zero step
//   thr_hit       one-cycle pulse: extended count arrived at threshold
//   evt_valid     FIFO head valid
//   evt_ready     consumer accepts head
//   evt_code      head mask: [0] wrap_up [1] wrap_down [2] jump [3] thr_hit
//   evt_value     ext_count after the event's update
//   evt_overflow  sticky: an event was dropped because the FIFO was full
module count_event_monitor #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned EXT_W      = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [WIDTH-1:0]       count,
    input  logic                   clear,
    input  logic [WIDTH+EXT_W-1:0] threshold,
    output logic [WIDTH+EXT_W-1:0] ext_count,
    output logic                   wrap_up,
    output logic                   wrap_down,
    output logic                   jump,
    output logic                   thr_hit,
    output logic                   evt_valid,
    input  logic                   evt_ready,
    output logic [3:0]             evt_code,
    output logic [WIDTH+EXT_W-1:0] evt_value,
    output logic                   evt_overflow
);

    localparam int unsigned XW    = WIDTH + EXT_W;
    localparam int unsigned EW    = XW + 4;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CW    = PTR_W + 1;

    localparam logic [WIDTH-1:0] CntMax  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CntZero = '0;
    localparam logic [WIDTH-1:0] CntOne  = WIDTH'(1);

    typedef enum logic {StInit, StTrack} trk_e;
    typedef enum logic {StArmed, StFired} thr_e;

    trk_e trk_q, trk_d;
    thr_e thr_q, thr_d;

    // Tracking datapath
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [EXT_W-1:0] upper_q, upper_d;
    logic [WIDTH-1:0] delta;
    logic [XW-1:0]    ext_d;
    logic             wu_q, wu_d;
    logic             wd_q, wd_d;
    logic             jmp_q, jmp_d;
    logic             hit_q, hit_d;

    // Event FIFO
    logic [EW-1:0]    mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [PTR_W-1:0] wr_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             valid_q;
    logic [EW-1:0]    head_q, head_d;
    logic             ovf_q;
    logic [3:0]       mask;
    logic [EW-1:0]    entry;
    logic             push_req, push, pop, full, ovf_set;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trk_q <= StInit;
            thr_q <= StArmed;
        end else begin
            trk_q <= trk_d;
            thr_q <= thr_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        trk_d = StTrack;
        thr_d = thr_q;
        if (clear) begin
            trk_d = StInit;
            thr_d = StArmed;
        end else if (trk_q == StTrack) begin
            unique case (thr_q)
                StArmed: if (ext_d == threshold) thr_d = StFired;
                StFired: if (ext_d != threshold) thr_d = StArmed;
                default: thr_d = StArmed;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM outputs: step classification and next extended value
    // ------------------------------------------------------------------
    assign delta = count - prev_q;

    always_comb begin
        prev_d  = count;
        upper_d = upper_q;
        wu_d    = 1'b0;
        wd_d    = 1'b0;
        jmp_d   = 1'b0;
        hit_d   = 1'b0;
        // INIT only captures; classification needs a valid previous sample.
        if (trk_q == StTrack) begin
            if (delta == CntOne) begin
                if (prev_q == CntMax) begin
                    wu_d    = 1'b1;
                    upper_d = upper_q + EXT_W'(1);
                end
            end else if (delta == CntMax) begin
                if (prev_q == CntZero) begin
                    wd_d    = 1'b1;
                    upper_d = upper_q - EXT_W'(1);
                end
            end else if (delta != CntZero) begin
                jmp_d = 1'b1;
            end
        end
        ext_d = {upper_d, prev_d};
        if (trk_q == StTrack && thr_q == StArmed && ext_d == threshold) begin
            hit_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    assign mask     = {hit_d, jmp_d, wd_d, wu_d};
    assign entry    = {mask, ext_d};
    assign full     = (cnt_q == CW'(FIFO_DEPTH));
    assign pop      = valid_q & evt_ready & ~clear;
    assign push_req = (|mask) & ~clear;
    // A pop in the same cycle frees the slot the push needs.
    assign push     = push_req & (~full | pop);
    assign ovf_set  = push_req & full & ~pop;
    assign rd_d     = rd_q + PTR_W'(pop);
    assign cnt_d    = cnt_q + CW'(push) - CW'(pop);

    // Next head; the entry being written this edge may itself become the head.
    always_comb begin
        head_d = mem_q[rd_d];
        if (push && (wr_q == rd_d)) begin
            head_d = entry;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q  <= '0;
            upper_q <= '0;
            wu_q    <= 1'b0;
            wd_q    <= 1'b0;
            jmp_q   <= 1'b0;
            hit_q   <= 1'b0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            head_q  <= '0;
            ovf_q   <= 1'b0;
        end else if (clear) begin
            // prev and the head register keep their values; nothing reads
            // them as live data until a new capture/push overwrites them.
            upper_q <= '0;
            wu_q    <= 1'b0;
            wd_q    <= 1'b0;
            jmp_q   <= 1'b0;
            hit_q   <= 1'b0;
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            upper_q <= upper_d;
            wu_q    <= wu_d;
            wd_q    <= wd_d;
            jmp_q   <= jmp_d;
            hit_q   <= hit_d;
            if (push) begin
                mem_q[wr_q] <= entry;
            end
            wr_q    <= wr_q + PTR_W'(push);
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            valid_q <= (cnt_d != '0);
            // When the FIFO empties the head keeps its last value.
            if (cnt_d != '0) begin
                head_q <= head_d;
            end
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign ext_count    = {upper_q, prev_q};
    assign wrap_up      = wu_q;
    assign wrap_down    = wd_q;
    assign jump         = jmp_q;
    assign thr_hit      = hit_q;
    assign evt_valid    = valid_q;
    assign evt_code     = head_q[EW-1:XW];
    assign evt_value    = head_q[XW-1:0];
    assign evt_overflow = ovf_q;

endmodule

// File: tb/tb_count_event_monitor.sv
// Self-checking bench for count_event_monitor: directed scenarios with literal
// expectations followed by a randomized phase, all compared every cycle
// against a behavioural model built from integers and a queue.
module tb_count_event_monitor;

    localparam int WIDTH = 4;
    localparam int EXT_W = 8;
    localparam int DEPTH = 4;
    localparam int XW    = WIDTH + EXT_W;
    localparam int CMAX  = (1 << WIDTH) - 1;
    localparam int UMAX  = (1 << EXT_W) - 1;
    localparam int NOHIT = 12'h800;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [3:0]    count;
    logic          clear;
    logic [XW-1:0] threshold;
    logic [XW-1:0] ext_count;
    logic          wrap_up, wrap_down, jump, thr_hit;
    logic          evt_valid, evt_ready;
    logic [3:0]    evt_code;
    logic [XW-1:0] evt_value;
    logic          evt_overflow;

    int checks = 0;
    int errors = 0;
    bit run_cmp = 1'b0;

    count_event_monitor #(
        .WIDTH(WIDTH),
        .EXT_W(EXT_W),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .count(count),
        .clear(clear),
        .threshold(threshold),
        .ext_count(ext_count),
        .wrap_up(wrap_up),
        .wrap_down(wrap_down),
        .jump(jump),
        .thr_hit(thr_hit),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_code(evt_code),
        .evt_value(evt_value),
        .evt_overflow(evt_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    int          m_prev = 0, m_upper = 0, m_track = 0, m_fired = 0, m_ovf = 0;
    int          m_wu = 0, m_wd = 0, m_jmp = 0, m_thr = 0;
    logic [15:0] m_q[$];
    logic [15:0] m_head = '0;

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_prev = 0; m_upper = 0; m_track = 0; m_fired = 0; m_ovf = 0;
                m_wu = 0; m_wd = 0; m_jmp = 0; m_thr = 0;
                m_q.delete();
                m_head = '0;
            end else if (clear) begin
                m_upper = 0; m_track = 0; m_fired = 0; m_ovf = 0;
                m_wu = 0; m_wd = 0; m_jmp = 0; m_thr = 0;
                m_q.delete();
            end else begin
                int d;
                int ext;
                int mask;
                bit pop;
                pop = (m_q.size() > 0) && evt_ready;
                m_wu = 0; m_wd = 0; m_jmp = 0; m_thr = 0;
                if (m_track == 0) begin
                    m_prev  = int'(count);
                    m_track = 1;
                end else begin
                    d = (int'(count) - m_prev) & CMAX;
                    if (d == 1 && m_prev == CMAX) begin
                        m_wu = 1;
                        m_upper = (m_upper + 1) & UMAX;
                    end
                    if (d == CMAX && m_prev == 0) begin
                        m_wd = 1;
                        m_upper = (m_upper - 1) & UMAX;
                    end
                    if (d != 0 && d != 1 && d != CMAX) m_jmp = 1;
                    m_prev = int'(count);
                    ext = m_upper * (CMAX + 1) + m_prev;
                    if (ext == int'(threshold)) begin
                        if (m_fired == 0) m_thr = 1;
                        m_fired = 1;
                    end else begin
                        m_fired = 0;
                    end
                end
                ext  = m_upper * (CMAX + 1) + m_prev;
                mask = m_wu + 2 * m_wd + 4 * m_jmp + 8 * m_thr;
                if (pop) void'(m_q.pop_front());
                if (mask != 0) begin
                    if (m_q.size() < DEPTH) m_q.push_back({4'(mask), 12'(ext)});
                    else m_ovf = 1;
                end
                if (m_q.size() > 0) m_head = m_q[0];
            end
        end
    end

    // Compare every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (run_cmp) begin
                chk("ext_count", ext_count, m_upper * (CMAX + 1) + m_prev);
                chk("wrap_up", wrap_up, m_wu);
                chk("wrap_down", wrap_down, m_wd);
                chk("jump", jump, m_jmp);
                chk("thr_hit", thr_hit, m_thr);
                chk("evt_valid", evt_valid, m_q.size() > 0);
                chk("evt_code", evt_code, m_head[15:12]);
                chk("evt_value", evt_value, m_head[11:0]);
                chk("evt_overflow", evt_overflow, m_ovf);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish, got running expected done");
        $fatal(1);
    end

    // Present a sample and advance to just after the edge that samples it.
    task automatic step(input logic [3:0] c);
        count = c;
        @(posedge clk);
        #1;
    endtask

    int n;
    int acc;
    logic [3:0] last_code;
    int exp_code [4] = '{1, 2, 1, 2};
    int exp_val  [4] = '{12'h010, 12'h00F, 12'h010, 12'h00F};

    initial begin
        reset_n   = 1'b0;
        count     = '0;
        clear     = 1'b0;
        threshold = XW'(NOHIT);
        evt_ready = 1'b1;
        #1;
        run_cmp = 1'b1;
        chk("reset ext_count", ext_count, 0);
        chk("reset evt_valid", evt_valid, 0);
        #11;
        reset_n = 1'b1;

        // 1: count up through the wrap
        step(4'd0);
        acc = 0;
        for (int i = 1; i < 16; i++) begin
            step(4'(i));
            acc += int'(wrap_up);
        end
        step(4'd0);
        acc += int'(wrap_up);
        chk("t1 wrap_up", wrap_up, 1);
        chk("t1 ext", ext_count, 12'h010);
        chk("t1 valid", evt_valid, 1);
        chk("t1 code", evt_code, 4'b0001);
        chk("t1 value", evt_value, 12'h010);
        step(4'd0);
        acc += int'(wrap_up);
        chk("t1 wrap_up count", acc, 1);

        // 2: wrap down, then underflow of upper
        step(4'd15);
        chk("t2 wrap_down", wrap_down, 1);
        chk("t2 ext", ext_count, 12'h00F);
        chk("t2 code", evt_code, 4'b0010);
        chk("t2 value", evt_value, 12'h00F);
        for (int i = 14; i >= 0; i--) step(4'(i));
        step(4'd15);
        chk("t2 upper wrap", ext_count, 12'hFFF);

        // 3: loads
        step(4'd3);
        step(4'd9);
        chk("t3 jump", jump, 1);
        chk("t3 ext", ext_count, 12'hFF9);
        chk("t3 code", evt_code, 4'b0100);
        step(4'd11);
        chk("t3 jump2", jump, 1);
        step(4'd9);
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            step(4'd9);
            acc += int'(wrap_up) + int'(wrap_down) + int'(jump) + int'(thr_hit);
        end
        chk("t3 hold quiet", acc, 0);

        // 4: threshold
        threshold = 12'h012;
        clear = 1'b1;
        step(4'd14);
        clear = 1'b0;
        step(4'd14);
        chk("t4 capture ext", ext_count, 12'h00E);
        step(4'd15); step(4'd0); step(4'd1); step(4'd2);
        chk("t4 thr_hit", thr_hit, 1);
        chk("t4 ext", ext_count, 12'h012);
        chk("t4 code", evt_code, 4'b1000);
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            step(4'd2);
            acc += int'(thr_hit);
        end
        chk("t4 no refire", acc, 0);
        step(4'd3);
        step(4'd2);
        chk("t4 refire", thr_hit, 1);
        threshold = 12'h010;
        step(4'd1); step(4'd0); step(4'd15); step(4'd0);
        chk("t4 coincident code", evt_code, 4'b1001);
        chk("t4 coincident value", evt_value, 12'h010);

        // 5: overflow and drain
        threshold = XW'(NOHIT);
        evt_ready = 1'b0;
        clear = 1'b1;
        step(4'd15);
        clear = 1'b0;
        step(4'd15);
        for (int k = 0; k < 6; k++) begin
            step((k % 2 == 0) ? 4'd0 : 4'd15);
            if (k == 3) begin
                chk("t5 full valid", evt_valid, 1);
                chk("t5 no ovf yet", evt_overflow, 0);
            end
            if (k == 4) chk("t5 ovf", evt_overflow, 1);
        end
        evt_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk("t5 drain code", evt_code, exp_code[j]);
            chk("t5 drain value", evt_value, exp_val[j]);
            step(4'd15);
        end
        chk("t5 drained", evt_valid, 0);
        evt_ready = 1'b0;
        step(4'd0); step(4'd15); step(4'd0); step(4'd15);
        evt_ready = 1'b1;
        step(4'd0);
        n = 0;
        last_code = '0;
        for (int i = 0; i < 10; i++) begin
            if (evt_valid) begin
                n++;
                last_code = evt_code;
            end
            step(4'd0);
        end
        chk("t5 full pop push count", n, 4);
        chk("t5 full pop push last", last_code, 4'b0001);
        clear = 1'b1;
        step(4'd0);
        clear = 1'b0;
        chk("t5 clear valid", evt_valid, 0);
        chk("t5 clear ovf", evt_overflow, 0);
        chk("t5 clear upper", ext_count[XW-1:WIDTH], 0);

        // 6: asynchronous reset with entries queued
        step(4'd0);
        evt_ready = 1'b0;
        step(4'd15); step(4'd0); step(4'd15);
        #3;
        reset_n = 1'b0;
        #1;
        chk("t6 rst ext", ext_count, 0);
        chk("t6 rst valid", evt_valid, 0);
        chk("t6 rst code", evt_code, 0);
        chk("t6 rst value", evt_value, 0);
        chk("t6 rst ovf", evt_overflow, 0);
        chk("t6 rst pulses", {wrap_up, wrap_down, jump, thr_hit}, 0);
        #3;
        reset_n = 1'b1;
        step(4'd15);
        chk("t6 capture quiet", {wrap_up, wrap_down, jump, thr_hit, evt_valid}, 0);
        step(4'd0);
        chk("t6 wrap_up", wrap_up, 1);
        chk("t6 ext", ext_count, 12'h010);

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            int r;
            logic [3:0] c;
            r = int'($urandom_range(0, 99));
            c = count;
            if (r < 30) c = count;
            else if (r < 55) c = count + 4'd1;
            else if (r < 80) c = count - 4'd1;
            else c = 4'($urandom_range(0, 15));
            evt_ready = ($urandom_range(0, 99) < 60);
            clear = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 49) == 0) begin
                if ($urandom_range(0, 1) == 0) threshold = XW'($urandom_range(0, 12'h02F));
                else threshold = XW'($urandom_range(12'hFD0, 12'hFFF));
            end
            step(c);
        end
        clear = 1'b0;
        step(count);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
